ysyx_22051468_shift_ctrl: RTL and testbench

//  Shift-unit controller for the RV64 EXU. Arbitrates NREQ requesters round-robin onto one

---
 rtl/ysyx_22051468_pkg.sv | 31 +++
 rtl/ysyx_22051468_Shift_64.sv | 37 +++
 rtl/ysyx_22051468_shift_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ysyx_22051468_shift_ctrl.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22051468_pkg.sv
// Shared shift-unit definitions: op encodings, op decode helpers and datapath width.
package ysyx_22051468_pkg;

   localparam int XLEN = 64;

   localparam logic [2:0] SHOP_SLL  = 3'b000;
   localparam logic [2:0] SHOP_SRL  = 3'b001;
   localparam logic [2:0] SHOP_SRA  = 3'b010;
   localparam logic [2:0] SHOP_SLLW = 3'b100;
   localparam logic [2:0] SHOP_SRLW = 3'b101;
   localparam logic [2:0] SHOP_SRAW = 3'b110;

   // Bit 2 of the op code marks the 32-bit (W) variants.
   function automatic logic is_w(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic is_left(input logic [2:0] op);
      return (op == SHOP_SLL) || (op == SHOP_SLLW);
   endfunction

   function automatic logic is_arith(input logic [2:0] op);
      return (op == SHOP_SRA) || (op == SHOP_SRAW);
   endfunction

   // 011 and 111 have no shift meaning.
   function automatic logic is_illegal(input logic [2:0] op);
      return op[1:0] == 2'b11;
   endfunction

endpackage

// File: rtl/ysyx_22051468_Shift_64.sv
// 64-bit barrel shifter. Left shifts reuse the right-shift network by bit-reversing
// the operand on the way in and the result on the way out.
module ysyx_22051468_Shift_64
   import ysyx_22051468_pkg::*;
(
   input  logic [XLEN-1:0] din,
   input  logic [5:0]      shamt,
   input  logic            LorR,
   input  logic            AorL,
   output logic [XLEN-1:0] dout
);

   logic            fill;
   logic [XLEN-1:0] cur;

   function automatic logic [XLEN-1:0] bitrev(input logic [XLEN-1:0] v);
      logic [XLEN-1:0] r;
      for (int i = 0; i < XLEN; i++) begin
         r[i] = v[XLEN-1-i];
      end
      return r;
   endfunction

   // Six log-steps of right shift; vacated bits take the sign only for arithmetic right shifts.
   always_comb begin
      fill = AorL & ~LorR & din[XLEN-1];
      cur  = LorR ? bitrev(din) : din;
      for (int s = 0; s < 6; s++) begin
         if (shamt[s]) begin
            cur = (cur >> (1 << s)) |
                  (fill ? ~({XLEN{1'b1}} >> (1 << s)) : {XLEN{1'b0}});
         end
      end
      dout = LorR ? bitrev(cur) : cur;
   end

endmodule

// File: rtl/ysyx_22051468_shift_ctrl.sv
// Shift-unit controller: round-robin arbitration of NREQ requesters onto one shared
// barrel shifter, behind a two-stage valid/ready pipeline (operand reg, result reg).
module ysyx_22051468_shift_ctrl #(
   parameter int NREQ = 2,
   parameter int IDW  = 4,
   parameter int XLEN = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*3-1:0]        req_op,
   input  logic [NREQ*XLEN-1:0]     req_data,
   input  logic [NREQ*6-1:0]        req_shamt,
   input  logic [NREQ*IDW-1:0]      req_tag,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [XLEN-1:0]          resp_data,
   output logic [$clog2(NREQ)-1:0]  resp_id,
   output logic [IDW-1:0]           resp_tag,
   output logic                     resp_err
);

   import ysyx_22051468_pkg::*;

   localparam int IW = $clog2(NREQ);

   // Pipeline control
   logic            vld_p1;
   logic            vld_p2;
   logic            adv2;
   logic            can_acc;
   logic            accept;

   // Arbiter
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   ptr_nxt;
   logic            grant_vld;
   logic [IW-1:0]   grant_idx;
   logic [IW:0]     cand;

   // Granted request payload
   logic [2:0]      op_sel;
   logic [XLEN-1:0] data_sel;
   logic [5:0]      shamt_sel;
   logic [IDW-1:0]  tag_sel;

   // Operand register
   logic [2:0]      op_p1;
   logic [XLEN-1:0] data_p1;
   logic [5:0]      shamt_p1;
   logic [IW-1:0]   id_p1;
   logic [IDW-1:0]  tag_p1;

   // Datapath between the operand and result registers
   logic            w_op;
   logic            left_op;
   logic            arith_op;
   logic            bad_op;
   logic [XLEN-1:0] opnd;
   logic [5:0]      shamt_eff;
   logic [XLEN-1:0] shres;
   logic [XLEN-1:0] result;

   assign adv2       = vld_p1 & (~vld_p2 | resp_ready);
   assign can_acc    = ~rst & ~flush & (~vld_p1 | adv2);
   assign accept     = grant_vld & can_acc;
   assign resp_valid = vld_p2;
   assign ptr_nxt    = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

   // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_ptr} + (IW+1)'(k);
         if (cand >= (IW+1)'(NREQ)) begin
            cand = cand - (IW+1)'(NREQ);
         end
         if (!grant_vld && req_valid[cand[IW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[IW-1:0];
         end
      end
   end

   // One-hot ready to the granted requester, plus payload selection for it.
   always_comb begin
      req_ready = '0;
      op_sel    = '0;
      data_sel  = '0;
      shamt_sel = '0;
      tag_sel   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == IW'(i)) begin
            req_ready[i] = grant_vld & can_acc;
            op_sel       = req_op[3*i +: 3];
            data_sel     = req_data[XLEN*i +: XLEN];
            shamt_sel    = req_shamt[6*i +: 6];
            tag_sel      = req_tag[IDW*i +: IDW];
         end
      end
   end

   // Pipeline occupancy and arbiter pointer; flush empties the pipe but keeps rr_ptr.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         rr_ptr <= '0;
      end else if (flush) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         if (accept) begin
            vld_p1 <= 1'b1;
            rr_ptr <= ptr_nxt;
         end else if (adv2) begin
            vld_p1 <= 1'b0;
         end
         if (adv2) begin
            vld_p2 <= 1'b1;
         end else if (resp_ready) begin
            vld_p2 <= 1'b0;
         end
      end
   end

   // ---- stage 0 -> 1: capture the granted request ----
   // Operand register loads on every accept; its contents are qualified by vld_p1.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_p1    <= op_sel;
         data_p1  <= data_sel;
         shamt_p1 <= shamt_sel;
         id_p1    <= grant_idx;
         tag_p1   <= tag_sel;
      end
   end

   // Decode and W-variant operand shaping ahead of the shared shifter.
   always_comb begin
      w_op      = is_w(op_p1);
      left_op   = is_left(op_p1);
      arith_op  = is_arith(op_p1);
      bad_op    = is_illegal(op_p1);
      opnd      = data_p1;
      shamt_eff = shamt_p1;
      if (w_op) begin
         shamt_eff = {1'b0, shamt_p1[4:0]};
         opnd      = arith_op ? {{32{data_p1[31]}}, data_p1[31:0]}
                              : {32'b0, data_p1[31:0]};
      end
   end

   ysyx_22051468_Shift_64 u_shift (
      .din   (opnd),
      .shamt (shamt_eff),
      .LorR  (left_op),
      .AorL  (arith_op),
      .dout  (shres)
   );

   // W results are sign-extended from bit 31; illegal ops produce zero.
   always_comb begin
      if (bad_op) begin
         result = '0;
      end else if (w_op) begin
         result = {{32{shres[31]}}, shres[31:0]};
      end else begin
         result = shres;
      end
   end

   // ---- stage 1 -> 2: result register, held while downstream stalls ----
   // Outputs have defined reset values, so this stage is reset as well.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_data <= '0;
         resp_err  <= 1'b0;
         resp_id   <= '0;
         resp_tag  <= '0;
      end else if (adv2 && !flush) begin
         resp_data <= result;
         resp_err  <= bad_op;
         resp_id   <= id_p1;
         resp_tag  <= tag_p1;
      end
   end

endmodule

// File: tb/tb_ysyx_22051468_shift_ctrl.sv
// Self-checking bench for ysyx_22051468_shift_ctrl: directed op vectors plus randomized
// streams scored against a queue-based reference of in-flight operations.
module tb_ysyx_22051468_shift_ctrl;

   localparam int NREQ = 2;
   localparam int IDW  = 4;
   localparam int IW   = 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 flush;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*3-1:0]    req_op;
   logic [NREQ*64-1:0]   req_data;
   logic [NREQ*6-1:0]    req_shamt;
   logic [NREQ*IDW-1:0]  req_tag;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [63:0]          resp_data;
   logic [IW-1:0]        resp_id;
   logic [IDW-1:0]       resp_tag;
   logic                 resp_err;

   typedef struct {
      logic [63:0]    data;
      logic           err;
      int             id;
      logic [IDW-1:0] tag;
   } exp_t;

   exp_t        q[$];
   bit          m_outv;
   int          m_ptr;
   int          n_chk;
   int          n_fail;
   int          n_seen;
   bit          auto_src;
   int          rate;
   bit          last_acc;
   int          last_g;
   logic [NREQ-1:0] obs_ready;

   always #5 clk = ~clk;

   ysyx_22051468_shift_ctrl #(.NREQ(NREQ), .IDW(IDW), .XLEN(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_data   (req_data),
      .req_shamt  (req_shamt),
      .req_tag    (req_tag),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .resp_tag   (resp_tag),
      .resp_err   (resp_err)
   );

   // Reference shift semantics written straight from the op table: {err, result}.
   function automatic logic [64:0] ref_shift(input logic [2:0] op, input logic [63:0] d,
                                             input logic [5:0] sh);
      logic [31:0]        lo;
      logic [31:0]        r32;
      logic [63:0]        r;
      logic signed [63:0] sd;
      logic signed [31:0] s32;
      lo  = d[31:0];
      sd  = d;
      s32 = lo;
      r32 = '0;
      case (op)
         3'b000: return {1'b0, d << sh};
         3'b001: return {1'b0, d >> sh};
         3'b010: begin r = sd >>> sh; return {1'b0, r}; end
         3'b100: r32 = lo << sh[4:0];
         3'b101: r32 = lo >> sh[4:0];
         3'b110: r32 = s32 >>> sh[4:0];
         default: return {1'b1, 64'd0};
      endcase
      return {1'b0, {{32{r32[31]}}, r32}};
   endfunction

   task automatic set_req(input int i, input logic [2:0] op, input logic [63:0] d,
                          input logic [5:0] sh, input logic [IDW-1:0] tag);
      req_op[3*i +: 3]       = op;
      req_data[64*i +: 64]   = d;
      req_shamt[6*i +: 6]    = sh;
      req_tag[IDW*i +: IDW]  = tag;
      req_valid[i]           = 1'b1;
   endtask

   task automatic new_req(input int i);
      set_req(i, 3'($urandom_range(0, 7)), {$urandom, $urandom}, 6'($urandom),
              IDW'($urandom));
   endtask

   // One clock of stimulus/observation. Compares the DUT against the reference at the
   // falling edge, then advances the reference across the rising edge.
   task automatic run_cycle(input string tn);
      int   g;
      int   s1_occ;
      bit   adv2;
      bit   can;
      bit   xfer;
      logic [NREQ-1:0] exp_rdy;
      logic [64:0] rs;
      exp_t e;
      @(negedge clk);
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (m_ptr + k) % NREQ;
         if (g < 0 && req_valid[idx]) g = idx;
      end
      s1_occ  = q.size() - (m_outv ? 1 : 0);
      adv2    = (s1_occ > 0) && (!m_outv || resp_ready);
      can     = !rst && !flush && (s1_occ == 0 || adv2);
      exp_rdy = '0;
      if (g >= 0 && can) exp_rdy[g] = 1'b1;
      obs_ready = req_ready;
      n_chk++;
      if (req_ready !== exp_rdy) begin
         n_fail++;
         $display("FAIL %s req_ready: got %b expected %b at %0t", tn, req_ready, exp_rdy, $time);
      end
      n_chk++;
      if (resp_valid !== m_outv) begin
         n_fail++;
         $display("FAIL %s resp_valid: got %b expected %b at %0t", tn, resp_valid, m_outv, $time);
      end
      if (m_outv) begin
         n_chk++;
         if (resp_data !== q[0].data || resp_err !== q[0].err || resp_tag !== q[0].tag ||
             int'(resp_id) != q[0].id) begin
            n_fail++;
            $display("FAIL %s resp payload: got data=%h err=%b id=%0d tag=%h expected data=%h err=%b id=%0d tag=%h at %0t",
                     tn, resp_data, resp_err, resp_id, resp_tag,
                     q[0].data, q[0].err, q[0].id, q[0].tag, $time);
         end
      end
      if (resp_valid === 1'b1 && resp_ready && !flush && !rst) n_seen++;
      xfer     = m_outv && resp_ready && !flush && !rst;
      last_acc = (exp_rdy != '0);
      last_g   = g;
      if (last_acc) begin
         rs     = ref_shift(req_op[3*g +: 3], req_data[64*g +: 64], req_shamt[6*g +: 6]);
         e.data = rs[63:0];
         e.err  = rs[64];
         e.id   = g;
         e.tag  = req_tag[IDW*g +: IDW];
      end
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_outv = 1'b0;
         m_ptr  = 0;
      end else if (flush) begin
         q.delete();
         m_outv = 1'b0;
      end else begin
         if (xfer) begin
            void'(q.pop_front());
            m_outv = 1'b0;
         end
         if (adv2) m_outv = 1'b1;
         if (last_acc) begin
            q.push_back(e);
            m_ptr = (g + 1) % NREQ;
         end
      end
      #1;
      if (last_acc) begin
         if (auto_src && $urandom_range(0, 99) < rate) new_req(g);
         else req_valid[g] = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!req_valid[i] && auto_src && $urandom_range(0, 99) < rate) new_req(i);
      end
   endtask

   task automatic drain();
      auto_src   = 1'b0;
      req_valid  = '0;
      resp_ready = 1'b1;
      flush      = 1'b0;
      repeat (4) run_cycle("drain");
   endtask

   // Single request on requester 0; reports acceptance, resp_valid one and two edges
   // after the accepting edge, and the delivered result.
   task automatic do_single(input logic [2:0] op, input logic [63:0] d, input logic [5:0] sh,
                            output bit acc_ok, output logic v0, output logic v1,
                            output logic [63:0] got, output logic got_err);
      int t;
      auto_src   = 1'b0;
      resp_ready = 1'b1;
      req_valid  = '0;
      set_req(0, op, d, sh, 4'h5);
      t = 0;
      do begin
         run_cycle("single");
         t++;
      end while (!last_acc && t < 20);
      acc_ok = last_acc;
      v0 = resp_valid;
      run_cycle("single");
      v1      = resp_valid;
      got     = resp_data;
      got_err = resp_err;
      run_cycle("single");
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      flush      = 1'b0;
      resp_ready = 1'b1;
      auto_src   = 1'b0;
      new_req(0);
      new_req(1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_chk++;
      if (req_ready !== '0) begin
         n_fail++; $display("FAIL reset req_ready: got %b expected 00", req_ready);
      end
      n_chk++;
      if (resp_valid !== 1'b0 || resp_data !== 64'd0 || resp_id !== '0 ||
          resp_tag !== '0 || resp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset outputs: got v=%b d=%h id=%0d tag=%h err=%b expected all zero",
                  resp_valid, resp_data, resp_id, resp_tag, resp_err);
      end
      rst       = 1'b0;
      req_valid = '0;
      q.delete();
      m_outv = 1'b0;
      m_ptr  = 0;
   endtask

   task automatic test_sra();
      bit acc; logic v0, v1, e; logic [63:0] r;
      do_single(3'b010, 64'h8000_0000_0000_0000, 6'd4, acc, v0, v1, r, e);
      n_chk++;
      if (!acc) begin n_fail++; $display("FAIL sra accept: got none expected within 20 cycles"); end
      n_chk++;
      if (v0 !== 1'b0 || v1 !== 1'b1) begin
         n_fail++; $display("FAIL sra latency: got v@N=%b v@N+1=%b expected 0 1", v0, v1);
      end
      n_chk++;
      if (r !== 64'hF800_0000_0000_0000 || e !== 1'b0) begin
         n_fail++; $display("FAIL sra result: got %h err=%b expected f800000000000000 err=0", r, e);
      end
   endtask

   task automatic test_w_ops();
      bit acc; logic v0, v1, e; logic [63:0] r;
      do_single(3'b110, 64'h0000_0000_8000_0000, 6'd36, acc, v0, v1, r, e);
      n_chk++;
      if (!acc || r !== 64'hFFFF_FFFF_F800_0000) begin
         n_fail++; $display("FAIL sraw result: got %h acc=%b expected fffffffff8000000", r, acc);
      end
      do_single(3'b101, 64'h0000_0000_8000_0000, 6'd36, acc, v0, v1, r, e);
      n_chk++;
      if (!acc || r !== 64'h0000_0000_0800_0000) begin
         n_fail++; $display("FAIL srlw result: got %h acc=%b expected 0000000008000000", r, acc);
      end
   endtask

   task automatic test_sll();
      bit acc; logic v0, v1, e; logic [63:0] r;
      do_single(3'b100, 64'h0000_0000_4000_0001, 6'd1, acc, v0, v1, r, e);
      n_chk++;
      if (!acc || r !== 64'hFFFF_FFFF_8000_0002) begin
         n_fail++; $display("FAIL sllw result: got %h acc=%b expected ffffffff80000002", r, acc);
      end
      do_single(3'b000, 64'd1, 6'd63, acc, v0, v1, r, e);
      n_chk++;
      if (!acc || r !== 64'h8000_0000_0000_0000) begin
         n_fail++; $display("FAIL sll63 result: got %h acc=%b expected 8000000000000000", r, acc);
      end
   endtask

   task automatic test_illegal();
      bit acc; logic v0, v1, e; logic [63:0] r;
      do_single(3'b011, 64'hDEAD_BEEF_1234_5678, 6'd5, acc, v0, v1, r, e);
      n_chk++;
      if (!acc || r !== 64'd0 || e !== 1'b1) begin
         n_fail++; $display("FAIL illegal011: got %h err=%b expected 0 err=1", r, e);
      end
      do_single(3'b111, 64'hFFFF_0000_FFFF_0000, 6'd9, acc, v0, v1, r, e);
      n_chk++;
      if (!acc || r !== 64'd0 || e !== 1'b1) begin
         n_fail++; $display("FAIL illegal111: got %h err=%b expected 0 err=1", r, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [NREQ-1:0] prev;
      drain();
      auto_src = 1'b1;
      rate     = 100;
      new_req(0);
      new_req(1);
      prev = '0;
      for (int c = 0; c < 20; c++) begin
         run_cycle("b2b");
         n_chk++;
         if ($countones(obs_ready) != 1 || obs_ready === prev) begin
            n_fail++;
            $display("FAIL b2b grant cycle %0d: got %b after %b expected alternating one-hot", c, obs_ready, prev);
         end
         prev = obs_ready;
         if (c >= 2) begin
            n_chk++;
            if (resp_valid !== 1'b1) begin
               n_fail++; $display("FAIL b2b throughput cycle %0d: got resp_valid %b expected 1", c, resp_valid);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int acc_cnt;
      int seen0;
      logic [63:0] snap_d;
      logic [IDW-1:0] snap_t;
      logic [IW-1:0] snap_i;
      drain();
      seen0      = n_seen;
      acc_cnt    = 0;
      resp_ready = 1'b0;
      auto_src   = 1'b1;
      rate       = 100;
      new_req(0);
      new_req(1);
      snap_d = '0; snap_t = '0; snap_i = '0;
      for (int c = 0; c < 5; c++) begin
         run_cycle("stall");
         if (obs_ready != '0) acc_cnt++;
         if (c == 1) begin snap_d = resp_data; snap_t = resp_tag; snap_i = resp_id; end
      end
      n_chk++;
      if (acc_cnt != 2) begin
         n_fail++; $display("FAIL stall accepts: got %0d expected 2", acc_cnt);
      end
      n_chk++;
      if (resp_valid !== 1'b1 || resp_data !== snap_d || resp_tag !== snap_t || resp_id !== snap_i) begin
         n_fail++;
         $display("FAIL stall hold: got v=%b d=%h tag=%h id=%0d expected v=1 d=%h tag=%h id=%0d",
                  resp_valid, resp_data, resp_tag, resp_id, snap_d, snap_t, snap_i);
      end
      resp_ready = 1'b1;
      auto_src   = 1'b0;
      for (int c = 0; c < 8; c++) begin
         run_cycle("release");
         if (obs_ready != '0) acc_cnt++;
      end
      n_chk++;
      if (n_seen - seen0 != acc_cnt || resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL release delivery: got %0d responses expected %0d (resp_valid=%b)",
                  n_seen - seen0, acc_cnt, resp_valid);
      end
   endtask

   task automatic fill_pipe();
      drain();
      resp_ready = 1'b0;
      new_req(0);
      new_req(1);
      repeat (3) run_cycle("fill");
   endtask

   task automatic test_flush_reset();
      int seen0;
      fill_pipe();
      n_chk++;
      if (resp_valid !== 1'b1) begin
         n_fail++; $display("FAIL flush setup: got resp_valid %b expected 1", resp_valid);
      end
      seen0      = n_seen;
      flush      = 1'b1;
      resp_ready = 1'b1;
      run_cycle("flush");
      flush = 1'b0;
      n_chk++;
      if (resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush clear: got resp_valid %b expected 0", resp_valid);
      end
      repeat (3) run_cycle("post_flush");
      n_chk++;
      if (n_seen != seen0) begin
         n_fail++; $display("FAIL flush spurious: got %0d responses expected 0", n_seen - seen0);
      end
      fill_pipe();
      rst   = 1'b1;
      flush = 1'b1;
      run_cycle("reset_mid");
      rst   = 1'b0;
      flush = 1'b0;
      n_chk++;
      if (resp_valid !== 1'b0 || resp_data !== 64'd0 || resp_tag !== '0) begin
         n_fail++;
         $display("FAIL reset mid-op: got v=%b d=%h tag=%h expected 0 0 0", resp_valid, resp_data, resp_tag);
      end
      resp_ready = 1'b1;
      new_req(0);
      new_req(1);
      #3;
      n_chk++;
      if (req_ready !== 2'b01) begin
         n_fail++; $display("FAIL reset rr_ptr: got req_ready %b expected 01", req_ready);
      end
      repeat (6) run_cycle("post_reset");
   endtask

   task automatic test_random();
      drain();
      auto_src = 1'b1;
      rate     = 60;
      for (int c = 0; c < 400; c++) begin
         resp_ready = ($urandom_range(0, 99) < 70);
         flush      = ($urandom_range(0, 99) < 2);
         run_cycle("random");
      end
      flush = 1'b0;
      drain();
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      n_seen    = 0;
      rate      = 100;
      auto_src  = 1'b0;
      rst       = 1'b1;
      flush     = 1'b0;
      resp_ready = 1'b1;
      req_valid = '0;
      req_op    = '0;
      req_data  = '0;
      req_shamt = '0;
      req_tag   = '0;
      m_outv    = 1'b0;
      m_ptr     = 0;
      test_reset();
      test_sra();
      test_w_ops();
      test_sll();
      test_illegal();
      test_back_to_back();
      test_backpressure();
      test_flush_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
